// File: rtl/rev_count_ctrl.sv
// rev_count_ctrl: start/stop/load controlled 16-bit up/down counter advanced by a prescaled tick
//   clk      in   system clock, rising edge
//   RST      in   asynchronous active-high reset
//   start    in   begin/resume counting (IDLE/PAUSE -> RUN)
//   stop     in   pause counting (RUN -> PAUSE)
//   load     in   load load_val into cnt and return to IDLE
//   load_val in   [15:0] value written on load
//   s        in   direction on tick cycles, 1 = up, 0 = down
//   wrap_en  in   1 = wrap at terminal count, 0 = halt in DONE
//   cnt      out  [15:0] registered count
//   Rc       out  registered one-cycle carry/borrow pulse
//   running  out  state is RUN
//   done     out  state is DONE
module rev_count_ctrl #(
    parameter int unsigned DIV = 10_000_000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic        stop,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        s,
    input  logic        wrap_en,
    output logic [15:0] cnt,
    output logic        Rc,
    output logic        running,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    localparam logic [23:0] PRE_LAST = 24'(DIV - 1);
    state_t      state_q, state_d;
    logic [23:0] pre_q, pre_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rc_q, rc_d;
    logic        tick, term, upd;
    always_ff @(posedge clk or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pre_q <= '0;
            cnt_q <= '0;
            rc_q  <= 1'b0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            rc_q  <= rc_d;
        end
    end
    // upd is a tick that actually takes effect: load or stop in the same cycle swallow it
    always_comb begin
        tick = (state_q == RUN) && (pre_q == PRE_LAST);
        term = s ? (cnt_q == 16'hFFFF) : (cnt_q == 16'h0000);
        upd  = tick && !load && !stop;
    end
    // stop outranks start even where stop itself has no effect
    always_comb begin
        state_d = state_q;
        if (load)
            state_d = IDLE;
        else if (stop)
            state_d = (state_q == RUN) ? PAUSE : state_q;
        else if (start && (state_q == IDLE || state_q == PAUSE))
            state_d = RUN;
        else if (upd && term && !wrap_en)
            state_d = DONE;
    end
    // prescaler restarts on load and on every RUN entry; frozen outside RUN
    always_comb begin
        pre_d = (load || (state_d == RUN && state_q != RUN)) ? '0 :
                (state_q == RUN && !stop) ? (tick ? '0 : pre_q + 24'd1) : pre_q;
        cnt_d = load ? load_val :
                (upd && (!term || wrap_en)) ? (s ? cnt_q + 16'd1 : cnt_q - 16'd1) : cnt_q;
        rc_d  = upd && term;
    end
    always_comb begin
        cnt     = cnt_q;
        Rc      = rc_q;
        running = (state_q == RUN);
        done    = (state_q == DONE);
    end
endmodule

// File: tb/tb_rev_count_ctrl.sv
// tb_rev_count_ctrl: directed scoreboard bench for rev_count_ctrl with DIV=4
module tb_rev_count_ctrl;
    logic        clk = 1'b0;
    logic        RST, start, stop, load, s, wrap_en;
    logic [15:0] load_val, cnt;
    logic        Rc, running, done;
    logic [18:0] obs;
    int          checks = 0;
    int          errors = 0;
    typedef struct {
        string       tag;
        logic [18:0] exp;
    } item_t;
    item_t q[$];

    rev_count_ctrl #(.DIV(4)) dut (
        .clk(clk), .RST(RST), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .s(s), .wrap_en(wrap_en),
        .cnt(cnt), .Rc(Rc), .running(running), .done(done)
    );

    always #5 clk = ~clk;
    assign obs = {cnt, Rc, running, done};

    task automatic push(input string tag, input logic [15:0] c, input logic r, input logic ru, input logic d);
        item_t it;
        it.tag = tag;
        it.exp = {c, r, ru, d};
        q.push_back(it);
    endtask

    task automatic pop_chk();
        item_t it;
        it = q.pop_front();
        checks++;
        assert (obs === it.exp) else begin
            errors++;
            $error("FAIL %s: {cnt,Rc,running,done} observed %h expected %h", it.tag, obs, it.exp);
        end
    endtask

    task automatic now_chk(input string tag, input logic [15:0] c, input logic r, input logic ru, input logic d);
        push(tag, c, r, ru, d);
        pop_chk();
    endtask

    task automatic step(input string tag, input logic [15:0] c, input logic r, input logic ru, input logic d);
        push(tag, c, r, ru, d);
        @(posedge clk);
        #1;
        pop_chk();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; s = 1'b1; wrap_en = 1'b1; load_val = '0;
        #1;
        now_chk("reset", 16'h0000, 0, 0, 0);
        @(posedge clk); #1;
        RST = 1'b0;
        step("idle", 16'h0000, 0, 0, 0);
        // basic up count: first tick 4 clk after RUN entry
        start = 1'b1;
        step("run_entry", 16'h0000, 0, 1, 0);
        start = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            for (int i = 0; i < 3; i++) step("up_wait", 16'(k - 1), 0, 1, 0);
            step("up_tick", 16'(k), 0, 1, 0);
        end
        // wrap up through FFFF
        load = 1'b1; load_val = 16'hFFFE;
        step("load_fffe", 16'hFFFE, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        step("wrap_start", 16'hFFFE, 0, 1, 0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) step("wrap_wait0", 16'hFFFE, 0, 1, 0);
        step("wrap_ffff", 16'hFFFF, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("wrap_wait1", 16'hFFFF, 0, 1, 0);
        step("wrap_rc", 16'h0000, 1, 1, 0);
        step("wrap_rc_low", 16'h0000, 0, 1, 0);
        // down to zero with halt
        s = 1'b0; wrap_en = 1'b0; load = 1'b1; load_val = 16'h0001;
        step("load_0001", 16'h0001, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        step("down_start", 16'h0001, 0, 1, 0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) step("down_wait0", 16'h0001, 0, 1, 0);
        step("down_zero", 16'h0000, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("down_wait1", 16'h0000, 0, 1, 0);
        step("halt_rc", 16'h0000, 1, 0, 1);
        step("halt_hold", 16'h0000, 0, 0, 1);
        start = 1'b1;
        step("done_start_ign", 16'h0000, 0, 0, 1);
        start = 1'b0;
        for (int i = 0; i < 4; i++) step("done_stay", 16'h0000, 0, 0, 1);
        // stop on a tick cycle
        s = 1'b1; wrap_en = 1'b1; load = 1'b1; load_val = 16'h0010;
        step("load_0010", 16'h0010, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        step("pause_start", 16'h0010, 0, 1, 0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) step("pause_wait0", 16'h0010, 0, 1, 0);
        step("pause_tick0", 16'h0011, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("pause_wait1", 16'h0011, 0, 1, 0);
        stop = 1'b1;
        step("stop_on_tick", 16'h0011, 0, 0, 0);
        stop = 1'b0;
        for (int i = 0; i < 3; i++) step("paused", 16'h0011, 0, 0, 0);
        start = 1'b1;
        step("resume", 16'h0011, 0, 1, 0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) step("resume_wait", 16'h0011, 0, 1, 0);
        step("resume_tick", 16'h0012, 0, 1, 0);
        // load beats stop beats start
        load = 1'b1; stop = 1'b1; start = 1'b1; load_val = 16'h1234;
        step("prio_load", 16'h1234, 0, 0, 0);
        load = 1'b0; stop = 1'b0; start = 1'b0;
        for (int i = 0; i < 2; i++) step("prio_idle", 16'h1234, 0, 0, 0);
        // asynchronous reset mid-RUN
        load = 1'b1; load_val = 16'h00A5;
        step("load_00a5", 16'h00A5, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        step("arst_start", 16'h00A5, 0, 1, 0);
        start = 1'b0;
        for (int i = 0; i < 2; i++) step("arst_run", 16'h00A5, 0, 1, 0);
        #2;
        RST = 1'b1;
        #1;
        now_chk("arst_now", 16'h0000, 0, 0, 0);
        #2;
        RST = 1'b0;
        for (int i = 0; i < 6; i++) step("arst_idle", 16'h0000, 0, 0, 0);
        start = 1'b1;
        step("arst_restart", 16'h0000, 0, 1, 0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) step("arst_wait", 16'h0000, 0, 1, 0);
        step("arst_tick", 16'h0001, 0, 1, 0);
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
